// File: rtl/bus_share_arbiter.sv
// Round-robin sharer of the result mux bus: one requester per grant, bursts of up to MAX_BURST beats.
// Grant 1 cycle after an IDLE request, data 1 cycle after transfer; req_ready drops while the output beat is stalled.
module bus_share_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [NUM_REQ-1:0]        req_last,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        grant,
  output logic                      out_valid,
  output logic [DATA_W-1:0]         out_data,
  output logic [2:0]                out_src,
  input  logic                      out_ready
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_e;

  state_e              state_q, state_d;
  logic [NUM_REQ-1:0]  grant_q, grant_d;
  logic [2:0]          last_q, last_d;
  logic [3:0]          beats_q, beats_d;
  logic                out_valid_q, out_valid_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic [2:0]          out_src_q, out_src_d;

  logic                win_found;
  logic [2:0]          win_idx;
  logic [NUM_REQ-1:0]  win_oh;
  int                  win_dist;

  logic                sel_valid;
  logic                sel_last;
  logic [DATA_W-1:0]   sel_data;

  logic                can_accept;
  logic                xfer;
  logic                beat_limit;
  logic                release_grant;

  // Scan distance of requester idx from the slot just after the last winner.
  function automatic int rr_dist(input int idx, input logic [2:0] ptr);
    return (idx + NUM_REQ - 1 - int'(ptr)) % NUM_REQ;
  endfunction

  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    win_oh    = '0;
    win_dist  = NUM_REQ;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_valid[i] && (rr_dist(i, last_q) < win_dist)) begin
        win_found = 1'b1;
        win_idx   = 3'(i);
        win_dist  = rr_dist(i, last_q);
        win_oh    = '0;
        win_oh[i] = 1'b1;
      end
    end
  end

  // Steer the granted requester onto the select path; grant_q is one-hot or zero.
  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_q[i]) begin
        sel_valid = req_valid[i];
        sel_last  = req_last[i];
        sel_data  = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign can_accept    = !out_valid_q || out_ready;
  assign xfer          = (state_q == BUSY) && sel_valid && can_accept;
  assign beat_limit    = ({1'b0, beats_q} + 5'd1) == 5'(MAX_BURST);
  assign release_grant = xfer && (sel_last || beat_limit);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      last_q      <= 3'(NUM_REQ - 1);
      beats_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      last_q      <= last_d;
      beats_q     <= beats_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    last_d      = last_q;
    beats_d     = beats_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;

    case (state_q)
      IDLE: begin
        if (win_found) begin
          state_d = BUSY;
          grant_d = win_oh;
          last_d  = win_idx;
          beats_d = '0;
        end
      end
      BUSY: begin
        if (release_grant) begin
          state_d = IDLE;
          grant_d = '0;
        end
      end
    endcase

    // A push overrides a same-cycle pop, so the register never bubbles mid-burst.
    if (xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = sel_data;
      out_src_d   = last_q;
      beats_d     = beats_q + 4'd1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_comb begin
    req_ready = '0;
    if ((state_q == BUSY) && can_accept) begin
      req_ready = grant_q;
    end
    grant     = grant_q;
    out_valid = out_valid_q;
    out_data  = out_data_q;
    out_src   = out_src_q;
  end

  grant_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(grant_q));
  grant_busy:   assert property (@(posedge clk) disable iff (rst) (state_q == BUSY) == (grant_q != '0));

endmodule

// File: doc/bus_share_arbiter.md
# bus_share_arbiter

Round-robin arbiter and sequencer that shares the TPU's 32-bit operand/result mux bus among `NUM_REQ` requesters. It chooses one requester at a time and holds that grant for a burst. It steers the granted requester's data through the select path into a one-entry output register. Each side uses a valid/ready handshake. It sits between the processing-element result ports and the shared writeback bus, and it is the block that drives the select inputs of the 2:1 mux tree.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters (2..8).
- `DATA_W`, 32: bus width.
- `MAX_BURST`, 4: maximum beats per grant (1..15).

Ports:
- `clk`  in  1: single clock; all logic on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `req_valid`  in  NUM_REQ: per-requester beat valid.
- `req_data`  in  NUM_REQ*DATA_W: requester i data is at bits [i*DATA_W +: DATA_W].
- `req_last`  in  NUM_REQ: marks the final beat of requester i's burst.
- `req_ready`  out  NUM_REQ: per-requester accept.
- `grant`  out  NUM_REQ: registered one-hot grant, all-zero when idle.
- `out_valid`  out  1: output register holds a beat.
- `out_data`  out  DATA_W: registered bus data.
- `out_src`  out  3: index of the requester that produced `out_data`.
- `out_ready`  in  1: downstream accept.

## Operation
- States are IDLE and BUSY. A burst counter `beats` is 4 bits wide. A round-robin pointer `last` holds the index of the most recent winner.
- On reset, the block goes to IDLE with `grant`=0, `beats`=0 and `last`=NUM_REQ-1, so requester 0 has top priority. Outputs reset to `out_valid`=0, `out_data`=0, `out_src`=0 and `req_ready`=0.
- In IDLE:
  - If any `req_valid` is set, the winner is the first asserted index scanning last+1, last+2, … modulo NUM_REQ.
  - On the next edge, `grant` becomes the one-hot winner, `last` takes the winner index, `beats` clears to 0, and the state moves to BUSY.
  - If no `req_valid` is set, the block stays in IDLE.
- In BUSY:
  - `req_ready[g]` = !out_valid | out_ready, where g is the granted index. All other `req_ready` bits are 0.
  - A transfer happens when `req_valid[g]` & `req_ready[g]`. On a transfer, `out_data`←`req_data[g]`, `out_src`←g, `out_valid`←1, and `beats`←beats+1.
  - The grant is released when the transfer carries `req_last[g]=1` or when beats+1 == MAX_BURST. On release, the next state is IDLE and `grant` returns to 0.
  - With no transfer, the grant is held indefinitely. A requester that deasserts `req_valid` mid-burst keeps the grant; there is no timeout.
- Output register:
  - `out_valid` clears when `out_ready` is high and no new transfer arrives in that cycle.
  - If a pop and a push happen in the same cycle, the new beat replaces the old one and `out_valid` stays 1.
  - While `out_valid` is 1 and `out_ready` is 0, `out_data` and `out_src` are stable and `req_ready` is all-zero.
- Requests from non-granted requesters are ignored until the next IDLE arbitration.

## Timing
- Grant latency: a request seen in IDLE at edge N produces `grant` at N+1. The first beat can transfer in the cycle after N+1 and appears on `out_valid` at N+2.
- Throughput: one beat per cycle during a burst while `out_ready` is held high.
- Each grant release is followed by one IDLE cycle, so back-to-back bursts lose one cycle.
- `req_ready` is combinational from `grant`, `out_valid` and `out_ready`. All other outputs are registered.
- Reset mid-burst: at the reset edge, the grant is dropped, any beat in the output register is discarded, and `last` returns to NUM_REQ-1.
- MAX_BURST=1: every transfer releases the grant.
- Pointer wrap: when last=NUM_REQ-1, the scan starts at index 0.
- `req_last` together with the burst-limit beat: a single release, identical to either condition alone.

## Test plan
- Single requester: reset, then req_valid=0001 with data 0xA5A5_0001…0xA5A5_0003 and last on the 3rd beat, out_ready=1. Expect `grant`=0001 one cycle after the request. Expect three consecutive beats on `out_data` with `out_src`=0, then `grant`=0 and one IDLE cycle.
- Round-robin fairness: all four requesters continuously valid, each with 1-beat bursts (last=1). Expect grant order 0,1,2,3,0,… with each grant separated by one IDLE cycle.
- Burst limit: requester 2 sends 6 beats with last never asserted, MAX_BURST=4. Expect exactly 4 beats, then release. Requester 2 is re-granted only after the other pending requesters have been served.
- Backpressure: out_ready=0 for 5 cycles mid-burst. Expect `out_data` stable, `req_ready`=0000 and no beat lost or duplicated. After out_ready returns to 1, the beat sequence continues in order.
- Reset mid-burst: rst=1 for one cycle after 2 beats of a 4-beat burst from requester 1. Expect `out_valid`=0 and `grant`=0 the next cycle. With requesters 0 and 1 both valid after reset, expect requester 0 to win.
- Simultaneous pop and push: out_valid=1 and out_ready=1 while a new beat 0x1234_5678 transfers. Expect `out_valid` to stay 1 and `out_data`=0x1234_5678 on the next cycle.
